coprocessor0_regfile: RTL and testbench
=======================================

Name: coprocessor0_regfile

Overview:
- CP0 register file and exception-state responder.
- Consumes the WBToCP0Data write channel from the write-back stage (MTC0), serves MFC0 reads, and applies exception and ERET updates committed in WB.
- Owns BadVAddr, Count, Compare, Status, Cause and EPC.
- Drives EPC, the interrupt-pending flag and the timer interrupt toward the fetch and exception logic.

Parameters:
- COUNT_DIVIDE, 2, Count increments once every COUNT_DIVIDE clocks. Legal values: 1 or 2.
- STATUS_BEV_RESET, 1, reset and hard-wired value of Status.boot_exception_vector.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- wb_to_cp0  in  WBToCP0Data  MTC0 address/select/write-enable/data from WB
- read_register  in  5  MFC0 register number
- read_select  in  3  MFC0 select
- read_data  out  32  MFC0 result; combinational from current register state
- exception_valid  in  1  exception committed in WB this cycle
- exception_code  in  5  ExcCode for Cause
- exception_pc  in  32  PC of the faulting instruction
- exception_in_delay_slot  in  1  faulting instruction is in a branch delay slot
- exception_has_bad_vaddr  in  1  BadVAddr must be loaded (AdEL/AdES)
- exception_bad_vaddr  in  32  faulting address
- eret  in  1  ERET committed in WB this cycle
- hardware_interrupt  in  6  external interrupt lines, sampled every clock
- status  out  StatusData  current Status
- cause  out  CauseData  current Cause
- epc  out  EPCData  current EPC, used as the ERET target
- interrupt_pending  out  1  equals (|(cause IP[7:0] & status.interrupt_mask)) && interrupt_enabled && !exception_level

Behaviour:
- Reset values. Status: all zero except BEV = STATUS_BEV_RESET. Cause, EPC, BadVAddr, Count and Compare: 0. Count divider phase: 0. interrupt_pending: 0.
- Register map (select must be 0, otherwise the address is unmapped): 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
- Unmapped addresses read as 0 and writes to them are ignored.
- MTC0 write occurs on the clock edge when write_enabled = 1. Per-register write rules:
  - Status: only interrupt_mask, exception_level and interrupt_enabled are writable. Zero fields stay 0; BEV is unaffected.
  - Cause: only software_interrupt[1:0] is writable.
  - Compare: loads the written value and clears Cause.timer_interrupt in the same edge.
  - Count: loads the written value and resets the divider phase to 0.
  - EPC: full 32-bit write.
- Count: increments by 1 when the divider phase wraps; wraps 0xFFFFFFFF to 0. An MTC0 write to Count in the same cycle takes precedence over the increment.
- Timer interrupt: set Cause.timer_interrupt on the edge where Count (pre-increment value) equals Compare and no Compare write occurs. The flag is sticky until Compare is written.
- Cause.hardware_interrupt[5:0] is registered from hardware_interrupt every clock; one cycle of latency.
- Hardware interrupt line 5 reads as hardware_interrupt[5] | timer_interrupt in the IP[7] position of interrupt_pending.
- Exception (exception_valid = 1):
  - exception_code is always loaded and exception_level is set to 1.
  - If the old exception_level = 0: EPC = exception_pc - 4 when exception_in_delay_slot, else exception_pc; Cause.in_delay_slot = exception_in_delay_slot.
  - If the old exception_level = 1: EPC and in_delay_slot are left unchanged.
  - BadVAddr is loaded only when exception_has_bad_vaddr = 1.
- ERET clears exception_level.
- Same-cycle priority: exception > ERET > MTC0. The losing actions are dropped completely. Count increment and hardware-interrupt sampling always proceed.
- Read-after-write: read_data reflects the old value in the same cycle and the new value from the next cycle. The pipeline handles forwarding; this block provides no bypass.
- Reset asserted mid-operation immediately forces all reset values, including divider phase and the sticky timer interrupt.

Decomposition:
- Add to the coprocessor0_params package:
  - CP0 register-number constants: CP0_BADVADDR = 8, CP0_COUNT = 9, CP0_COMPARE = 11, CP0_STATUS = 12, CP0_CAUSE = 13, CP0_EPC = 14.
  - An ExceptionCode enum: Int = 0, AdEL = 4, AdES = 5, Sys = 8, Bp = 9, RI = 10, Ov = 12.
  - A packed WBExceptionData struct grouping the exception_* inputs.
- One sub-module, cp0_timer, holds Count, Compare, the divider and the timer_interrupt flag. It takes the decoded Count/Compare write strobes and returns count, compare and timer_interrupt.

Test Plan:
- Reset, then MFC0 reg 12 -> 0x00400000; reg 13/14 -> 0; interrupt_pending = 0.
- MTC0 Status with 0xFFFFFFFF -> reads 0x0040FF03. MTC0 Cause with 0xFFFFFFFF -> reads 0x00000300.
- Exception with code 4, pc 0xBFC00100, delay slot = 1, bad vaddr 0x1233 -> EPC = 0xBFC000FC, Cause = 0x80000010, BadVAddr = 0x1233, EXL = 1. A second exception with code 12 -> EPC unchanged, Cause code = 12. ERET -> EXL = 0.
- Same cycle: exception plus MTC0 to EPC with 0x1234 -> EPC holds the exception PC, not 0x1234.
- Write Compare = 5 and Count = 0 with COUNT_DIVIDE = 2 -> timer_interrupt rises after Count reaches 5 (~10 clocks). With Status = 0x00008001 -> interrupt_pending = 1. Rewriting Compare -> both drop to 0.
- hardware_interrupt = 6'b000001 with IM = 0x04, IE = 1 -> interrupt_pending = 1 one cycle later. Assert reset asynchronously mid-count -> all registers return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/coprocessor0_regfile_pkg.sv
// coprocessor0_params: shared types and constants for the CP0 register file.
//   - CP0 register numbers used for MTC0/MFC0 decode
//   - ExceptionCode values loaded into Cause.ExcCode
//   - WBToCP0Data: MTC0 channel from the write-back stage
//   - WBExceptionData: exception commit information from write-back
//   - StatusData / CauseData / EPCData: architectural register layouts
package coprocessor0_params;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    Int  = 5'd0,
    AdEL = 5'd4,
    AdES = 5'd5,
    Sys  = 5'd8,
    Bp   = 5'd9,
    RI   = 5'd10,
    Ov   = 5'd12
  } ExceptionCode;

  typedef struct packed {
    logic [4:0]  address;
    logic [2:0]  select;
    logic        write_enabled;
    logic [31:0] data;
  } WBToCP0Data;

  typedef struct packed {
    logic        valid;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic        has_bad_vaddr;
    logic [31:0] bad_vaddr;
  } WBExceptionData;

  typedef struct packed {
    logic [8:0] zero_31_23;
    logic       boot_exception_vector;
    logic [5:0] zero_21_16;
    logic [7:0] interrupt_mask;
    logic [5:0] zero_7_2;
    logic       exception_level;
    logic       interrupt_enabled;
  } StatusData;

  typedef struct packed {
    logic        in_delay_slot;
    logic        timer_interrupt;
    logic [13:0] zero_29_16;
    logic [5:0]  hardware_interrupt;
    logic [1:0]  software_interrupt;
    logic        zero_7;
    logic [4:0]  exception_code;
    logic [1:0]  zero_1_0;
  } CauseData;

  typedef logic [31:0] EPCData;

  // True when the MTC0 channel carries a write to the given select-0 register.
  function automatic logic mtc0_hits(input WBToCP0Data wb, input logic [4:0] reg_num);
    return wb.write_enabled && (wb.select == 3'd0) && (wb.address == reg_num);
  endfunction

endpackage

// File: rtl/coprocessor0_regfile_timer.sv
// cp0_timer: Count/Compare timer for CP0.
//   clock, reset      core clock, async active-high reset
//   write_count       load Count from write_data, restart the divider
//   write_compare     load Compare from write_data, clear timer_interrupt
//   write_data        MTC0 data
//   count, compare    current register values
//   timer_interrupt   sticky Count==Compare flag
module cp0_timer #(
  parameter int COUNT_DIVIDE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_count,
  input  logic        write_compare,
  input  logic [31:0] write_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_interrupt
);

  // With a divide of 1 the last phase is 0, so every clock is a tick.
  localparam logic PHASE_LAST = 1'(COUNT_DIVIDE - 1);

  logic        phase_q, phase_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_interrupt_q, timer_interrupt_d;
  logic        tick;

  // The match test uses the pre-increment Count; a Compare write in the
  // same edge both loads Compare and wins over a match.
  always_comb begin
    tick              = (phase_q == PHASE_LAST);
    phase_d           = tick ? 1'b0 : phase_q + 1'b1;
    count_d           = tick ? count_q + 32'd1 : count_q;
    compare_d         = compare_q;
    timer_interrupt_d = timer_interrupt_q;
    if (count_q == compare_q) begin
      timer_interrupt_d = 1'b1;
    end
    if (write_compare) begin
      compare_d         = write_data;
      timer_interrupt_d = 1'b0;
    end
    if (write_count) begin
      count_d = write_data;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q           <= 1'b0;
      count_q           <= '0;
      compare_q         <= '0;
      timer_interrupt_q <= 1'b0;
    end else begin
      phase_q           <= phase_d;
      count_q           <= count_d;
      compare_q         <= compare_d;
      timer_interrupt_q <= timer_interrupt_d;
    end
  end

  assign count           = count_q;
  assign compare         = compare_q;
  assign timer_interrupt = timer_interrupt_q;

endmodule

// File: rtl/coprocessor0_regfile.sv
// coprocessor0_regfile: CP0 register file and exception-state responder.
//   clock, reset               core clock, async active-high reset
//   wb_to_cp0                  MTC0 write channel from write-back
//   read_register/read_select  MFC0 address; read_data is combinational
//   exception_*                exception committed in write-back this cycle
//   eret                       ERET committed in write-back this cycle
//   hardware_interrupt         external interrupt lines, sampled each clock
//   status, cause, epc         current architectural state
//   interrupt_pending          enabled, unmasked interrupt outside EXL
import coprocessor0_params::*;

module coprocessor0_regfile #(
  parameter int   COUNT_DIVIDE     = 2,
  parameter logic STATUS_BEV_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  WBToCP0Data  wb_to_cp0,
  input  logic [4:0]  read_register,
  input  logic [2:0]  read_select,
  output logic [31:0] read_data,
  input  logic        exception_valid,
  input  logic [4:0]  exception_code,
  input  logic [31:0] exception_pc,
  input  logic        exception_in_delay_slot,
  input  logic        exception_has_bad_vaddr,
  input  logic [31:0] exception_bad_vaddr,
  input  logic        eret,
  input  logic [5:0]  hardware_interrupt,
  output StatusData   status,
  output CauseData    cause,
  output EPCData      epc,
  output logic        interrupt_pending
);

  WBExceptionData exc;
  StatusData      status_q, status_d;
  CauseData       cause_q, cause_d;
  EPCData         epc_q, epc_d;
  logic [31:0]    badvaddr_q, badvaddr_d;
  logic [31:0]    count, compare;
  logic           timer_interrupt;
  logic           mtc0_allowed;
  logic           write_count, write_compare;
  logic [7:0]     interrupt_lines;

  assign exc = '{valid:         exception_valid,
                 code:          exception_code,
                 pc:            exception_pc,
                 in_delay_slot: exception_in_delay_slot,
                 has_bad_vaddr: exception_has_bad_vaddr,
                 bad_vaddr:     exception_bad_vaddr};

  // Exception beats ERET beats MTC0; a losing MTC0 is dropped entirely,
  // including its side effects on the timer.
  assign mtc0_allowed  = !exc.valid && !eret;
  assign write_count   = mtc0_allowed && mtc0_hits(wb_to_cp0, CP0_COUNT);
  assign write_compare = mtc0_allowed && mtc0_hits(wb_to_cp0, CP0_COMPARE);

  cp0_timer #(
    .COUNT_DIVIDE (COUNT_DIVIDE)
  ) u_timer (
    .clock           (clock),
    .reset           (reset),
    .write_count     (write_count),
    .write_compare   (write_compare),
    .write_data      (wb_to_cp0.data),
    .count           (count),
    .compare         (compare),
    .timer_interrupt (timer_interrupt)
  );

  // A nested exception (EXL already set) keeps the original EPC and BD so
  // the handler can still return to the first faulting instruction.
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    cause_d.hardware_interrupt = hardware_interrupt;

    if (exc.valid) begin
      cause_d.exception_code = exc.code;
      if (!status_q.exception_level) begin
        epc_d                 = exc.in_delay_slot ? exc.pc - 32'd4 : exc.pc;
        cause_d.in_delay_slot = exc.in_delay_slot;
      end
      status_d.exception_level = 1'b1;
      if (exc.has_bad_vaddr) begin
        badvaddr_d = exc.bad_vaddr;
      end
    end else if (eret) begin
      status_d.exception_level = 1'b0;
    end else begin
      if (mtc0_hits(wb_to_cp0, CP0_STATUS)) begin
        status_d.interrupt_mask    = wb_to_cp0.data[15:8];
        status_d.exception_level   = wb_to_cp0.data[1];
        status_d.interrupt_enabled = wb_to_cp0.data[0];
      end
      if (mtc0_hits(wb_to_cp0, CP0_CAUSE)) begin
        cause_d.software_interrupt = wb_to_cp0.data[9:8];
      end
      if (mtc0_hits(wb_to_cp0, CP0_EPC)) begin
        epc_d = wb_to_cp0.data;
      end
    end

    status_d.boot_exception_vector = STATUS_BEV_RESET;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_q                       <= '0;
      status_q.boot_exception_vector <= STATUS_BEV_RESET;
      cause_q                        <= '0;
      epc_q                          <= '0;
      badvaddr_q                     <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // The timer flag lives in cp0_timer; it is merged into Cause here.
  always_comb begin
    cause                 = cause_q;
    cause.timer_interrupt = timer_interrupt;
  end

  assign status = status_q;
  assign epc    = epc_q;

  // The timer shares IP[7] with hardware line 5.
  assign interrupt_lines = {cause.hardware_interrupt[5] | timer_interrupt,
                            cause.hardware_interrupt[4:0],
                            cause.software_interrupt};

  assign interrupt_pending = (|(interrupt_lines & status_q.interrupt_mask)) &&
                             status_q.interrupt_enabled && !status_q.exception_level;

  always_comb begin
    read_data = '0;
    if (read_select == 3'd0) begin
      case (read_register)
        CP0_BADVADDR: read_data = badvaddr_q;
        CP0_COUNT:    read_data = count;
        CP0_COMPARE:  read_data = compare;
        CP0_STATUS:   read_data = status_q;
        CP0_CAUSE:    read_data = cause;
        CP0_EPC:      read_data = epc_q;
        default:      read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_coprocessor0_regfile.sv
// Self-checking bench for coprocessor0_regfile. A word-level reference
// model (masks and plain arithmetic) is advanced once per clock from the
// inputs presented before the edge.
import coprocessor0_params::*;

module tb_coprocessor0_regfile;

  localparam int DIV = 2;

  logic        clock = 1'b0;
  logic        reset;
  WBToCP0Data  wb;
  logic [4:0]  read_register;
  logic [2:0]  read_select;
  logic [31:0] read_data;
  logic        exception_valid;
  logic [4:0]  exception_code;
  logic [31:0] exception_pc;
  logic        exception_in_delay_slot;
  logic        exception_has_bad_vaddr;
  logic [31:0] exception_bad_vaddr;
  logic        eret;
  logic [5:0]  hardware_interrupt;
  StatusData   status;
  CauseData    cause;
  EPCData      epc;
  logic        interrupt_pending;

  int checks = 0;
  int errors = 0;

  // Reference model state (Cause kept without the timer bit).
  logic [31:0] m_status, m_cause, m_epc, m_badvaddr, m_count, m_compare;
  int          m_ticks;
  logic        m_ti;

  coprocessor0_regfile #(
    .COUNT_DIVIDE     (DIV),
    .STATUS_BEV_RESET (1'b1)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .wb_to_cp0               (wb),
    .read_register           (read_register),
    .read_select             (read_select),
    .read_data               (read_data),
    .exception_valid         (exception_valid),
    .exception_code          (exception_code),
    .exception_pc            (exception_pc),
    .exception_in_delay_slot (exception_in_delay_slot),
    .exception_has_bad_vaddr (exception_has_bad_vaddr),
    .exception_bad_vaddr     (exception_bad_vaddr),
    .eret                    (eret),
    .hardware_interrupt      (hardware_interrupt),
    .status                  (status),
    .cause                   (cause),
    .epc                     (epc),
    .interrupt_pending       (interrupt_pending)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_status   = 32'h0040_0000;
    m_cause    = '0;
    m_epc      = '0;
    m_badvaddr = '0;
    m_count    = '0;
    m_compare  = '0;
    m_ticks    = 0;
    m_ti       = 1'b0;
  endtask

  function automatic logic [31:0] m_cause_word();
    return m_cause | {1'b0, m_ti, 30'b0};
  endfunction

  function automatic logic m_pending();
    logic [7:0] ip;
    ip    = m_cause[15:8];
    ip[7] = ip[7] | m_ti;
    return (|(ip & m_status[15:8])) && m_status[0] && !m_status[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s != 3'd0) return 32'h0;
    case (a)
      5'd8:    return m_badvaddr;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause_word();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic clear_inputs();
    wb                      = '0;
    read_register           = '0;
    read_select             = '0;
    exception_valid         = 1'b0;
    exception_code          = '0;
    exception_pc            = '0;
    exception_in_delay_slot = 1'b0;
    exception_has_bad_vaddr = 1'b0;
    exception_bad_vaddr     = '0;
    eret                    = 1'b0;
    hardware_interrupt      = '0;
  endtask

  // Compute the model's next state from the current inputs, take one clock,
  // then commit the model and drop the one-shot requests.
  task automatic step_cycle();
    logic [31:0] n_status, n_cause, n_epc, n_badvaddr, n_count, n_compare;
    int          n_ticks;
    logic        n_ti, exc, er, wr;
    n_status = m_status; n_epc = m_epc; n_badvaddr = m_badvaddr;
    n_count = m_count; n_compare = m_compare; n_ti = m_ti;
    exc = exception_valid;
    er  = eret && !exc;
    wr  = wb.write_enabled && !exc && !er && (wb.select == 3'd0);

    if (wr && wb.address == 5'd11) begin
      n_compare = wb.data;
      n_ti      = 1'b0;
    end else if (m_count == m_compare) begin
      n_ti = 1'b1;
    end
    if (wr && wb.address == 5'd9) begin
      n_count = wb.data;
      n_ticks = 0;
    end else if (m_ticks + 1 == DIV) begin
      n_count = m_count + 32'd1;
      n_ticks = 0;
    end else begin
      n_ticks = m_ticks + 1;
    end

    n_cause = (m_cause & ~32'h0000_FC00) | ({26'b0, hardware_interrupt} << 10);
    if (exc) begin
      n_cause = (n_cause & ~32'h0000_007C) | ({27'b0, exception_code} << 2);
      if (!m_status[1]) begin
        n_epc   = exception_in_delay_slot ? exception_pc - 32'd4 : exception_pc;
        n_cause = exception_in_delay_slot ? (n_cause | 32'h8000_0000)
                                          : (n_cause & ~32'h8000_0000);
      end
      n_status = n_status | 32'h2;
      if (exception_has_bad_vaddr) n_badvaddr = exception_bad_vaddr;
    end else if (er) begin
      n_status = n_status & ~32'h2;
    end else if (wr) begin
      case (wb.address)
        5'd12:   n_status = (m_status & ~32'h0000_FF03) | (wb.data & 32'h0000_FF03);
        5'd13:   n_cause  = (n_cause & ~32'h0000_0300) | (wb.data & 32'h0000_0300);
        5'd14:   n_epc    = wb.data;
        default: ;
      endcase
    end

    @(posedge clock);
    m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badvaddr = n_badvaddr;
    m_count = n_count; m_compare = n_compare; m_ticks = n_ticks; m_ti = n_ti;
    #1;
    wb.write_enabled = 1'b0;
    exception_valid  = 1'b0;
    eret             = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wb.address = a; wb.select = 3'd0; wb.write_enabled = 1'b1; wb.data = d;
    step_cycle();
  endtask

  task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
    read_register = a;
    read_select   = 3'd0;
    #1;
    d = read_data;
  endtask

  task automatic raise_exception(input logic [4:0] code, input logic [31:0] pc,
                                 input logic ds, input logic hb, input logic [31:0] bv);
    exception_valid = 1'b1; exception_code = code; exception_pc = pc;
    exception_in_delay_slot = ds; exception_has_bad_vaddr = hb; exception_bad_vaddr = bv;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    clear_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    mfc0(5'd12, d);
    checks++; if (d !== 32'h0040_0000) begin errors++; $display("[TB] FAIL reset_status got %h want %h", d, 32'h0040_0000); end
    mfc0(5'd13, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_cause got %h want %h", d, 32'h0); end
    mfc0(5'd14, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_epc got %h want %h", d, 32'h0); end
    checks++; if (interrupt_pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending got %b want 0", interrupt_pending); end
    reset = 1'b0;
    // Park Compare far away so the timer stays quiet in the early tests.
    mtc0(5'd11, 32'hFFFF_FFF0);
  endtask

  task automatic test_write_masks();
    logic [31:0] d;
    mtc0(5'd12, 32'hFFFF_FFFF);
    mfc0(5'd12, d);
    checks++; if (d !== 32'h0040_FF03) begin errors++; $display("[TB] FAIL status_mask got %h want %h", d, 32'h0040_FF03); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    mfc0(5'd13, d);
    checks++; if (d !== 32'h0000_0300) begin errors++; $display("[TB] FAIL cause_mask got %h want %h", d, 32'h0000_0300); end
    wb.select = 3'd1;
    wb.address = 5'd14; wb.data = 32'hCAFE_0000; wb.write_enabled = 1'b1;
    step_cycle();
    mfc0(5'd14, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_select_write got %h want %h", d, 32'h0); end
    read_select = 3'd1; read_register = 5'd12; #1;
    checks++; if (read_data !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_select_read got %h want %h", read_data, 32'h0); end
    mtc0(5'd12, 32'h0);
    mtc0(5'd13, 32'h0);
  endtask

  task automatic test_exception();
    logic [31:0] d;
    raise_exception(5'd4, 32'hBFC0_0100, 1'b1, 1'b1, 32'h0000_1233);
    step_cycle();
    checks++; if (epc !== 32'hBFC0_00FC) begin errors++; $display("[TB] FAIL exc_epc got %h want %h", epc, 32'hBFC0_00FC); end
    mfc0(5'd13, d);
    checks++; if (d !== 32'h8000_0010) begin errors++; $display("[TB] FAIL exc_cause got %h want %h", d, 32'h8000_0010); end
    mfc0(5'd8, d);
    checks++; if (d !== 32'h0000_1233) begin errors++; $display("[TB] FAIL exc_badvaddr got %h want %h", d, 32'h0000_1233); end
    checks++; if (status.exception_level !== 1'b1) begin errors++; $display("[TB] FAIL exc_exl got %b want 1", status.exception_level); end
    raise_exception(5'd12, 32'h8000_0200, 1'b0, 1'b0, 32'hFFFF_0000);
    step_cycle();
    checks++; if (epc !== 32'hBFC0_00FC) begin errors++; $display("[TB] FAIL nested_epc got %h want %h", epc, 32'hBFC0_00FC); end
    mfc0(5'd13, d);
    checks++; if (d !== 32'h8000_0030) begin errors++; $display("[TB] FAIL nested_cause got %h want %h", d, 32'h8000_0030); end
    mfc0(5'd8, d);
    checks++; if (d !== 32'h0000_1233) begin errors++; $display("[TB] FAIL nested_badvaddr got %h want %h", d, 32'h0000_1233); end
    eret = 1'b1;
    step_cycle();
    checks++; if (status !== 32'h0040_0000) begin errors++; $display("[TB] FAIL eret_status got %h want %h", status, 32'h0040_0000); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    raise_exception(5'd8, 32'h8000_1000, 1'b0, 1'b0, 32'h0);
    wb.address = 5'd14; wb.select = 3'd0; wb.data = 32'h0000_1234; wb.write_enabled = 1'b1;
    step_cycle();
    checks++; if (epc !== 32'h8000_1000) begin errors++; $display("[TB] FAIL exc_over_mtc0 got %h want %h", epc, 32'h8000_1000); end
    eret = 1'b1;
    wb.address = 5'd12; wb.data = 32'h0000_0003; wb.write_enabled = 1'b1;
    step_cycle();
    mfc0(5'd12, d);
    checks++; if (d !== 32'h0040_0000) begin errors++; $display("[TB] FAIL eret_over_mtc0 got %h want %h", d, 32'h0040_0000); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    int          cycles;
    bit          rose;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    cycles = 0;
    rose   = 1'b0;
    while (!rose && cycles < 40) begin
      step_cycle();
      cycles++;
      checks++; if (cause !== m_cause_word()) begin errors++; $display("[TB] FAIL timer_cause got %h want %h", cause, m_cause_word()); end
      rose = cause.timer_interrupt;
    end
    checks++; if (cycles !== 5 * DIV + 1) begin errors++; $display("[TB] FAIL timer_latency got %0d want %0d", cycles, 5 * DIV + 1); end
    mfc0(5'd9, d);
    checks++; if (d !== 32'd5) begin errors++; $display("[TB] FAIL timer_count got %h want %h", d, 32'd5); end
    mtc0(5'd12, 32'h0000_8001);
    checks++; if (interrupt_pending !== 1'b1) begin errors++; $display("[TB] FAIL timer_pending got %b want 1", interrupt_pending); end
    mtc0(5'd11, 32'hFFFF_FFF0);
    checks++; if (cause.timer_interrupt !== 1'b0) begin errors++; $display("[TB] FAIL timer_clear got %b want 0", cause.timer_interrupt); end
    checks++; if (interrupt_pending !== 1'b0) begin errors++; $display("[TB] FAIL timer_pending_clear got %b want 0", interrupt_pending); end
  endtask

  task automatic test_hw_interrupt();
    mtc0(5'd12, 32'h0000_0401);
    hardware_interrupt = 6'b000001;
    #1;
    checks++; if (interrupt_pending !== 1'b0) begin errors++; $display("[TB] FAIL hw_before_edge got %b want 0", interrupt_pending); end
    step_cycle();
    checks++; if (interrupt_pending !== 1'b1) begin errors++; $display("[TB] FAIL hw_pending got %b want 1", interrupt_pending); end
    hardware_interrupt = 6'b000000;
    step_cycle();
    checks++; if (interrupt_pending !== 1'b0) begin errors++; $display("[TB] FAIL hw_release got %b want 0", interrupt_pending); end
  endtask

  task automatic test_random();
    logic [4:0] map [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd10};
    int         r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      hardware_interrupt = 6'($urandom);
      eret               = (r < 8);
      exception_valid    = (r >= 90);
      exception_code     = 5'($urandom);
      exception_pc       = $urandom;
      exception_in_delay_slot = 1'($urandom);
      exception_has_bad_vaddr = 1'($urandom);
      exception_bad_vaddr     = $urandom;
      wb.write_enabled = ($urandom_range(0, 2) != 0);
      wb.address       = ($urandom_range(0, 9) == 0) ? 5'($urandom) : map[$urandom_range(0, 6)];
      wb.select        = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
      wb.data          = $urandom;
      if (wb.address == 5'd11 && $urandom_range(0, 1) == 1) wb.data = m_count + 32'($urandom_range(0, 6));
      read_register    = ($urandom_range(0, 9) == 0) ? 5'($urandom) : map[$urandom_range(0, 6)];
      read_select      = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
      step_cycle();
      checks++; if (read_data !== m_read(read_register, read_select)) begin errors++; $display("[TB] FAIL rand_read reg %0d got %h want %h", read_register, read_data, m_read(read_register, read_select)); end
      checks++; if (status !== m_status) begin errors++; $display("[TB] FAIL rand_status got %h want %h", status, m_status); end
      checks++; if (cause !== m_cause_word()) begin errors++; $display("[TB] FAIL rand_cause got %h want %h", cause, m_cause_word()); end
      checks++; if (epc !== m_epc) begin errors++; $display("[TB] FAIL rand_epc got %h want %h", epc, m_epc); end
      checks++; if (interrupt_pending !== m_pending()) begin errors++; $display("[TB] FAIL rand_pending got %b want %b", interrupt_pending, m_pending()); end
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd14, 32'hDEAD_BEEF);
    mtc0(5'd11, 32'h0000_0100);
    mtc0(5'd9, 32'h0000_0100);
    repeat (3) step_cycle();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (status !== 32'h0040_0000) begin errors++; $display("[TB] FAIL areset_status got %h want %h", status, 32'h0040_0000); end
    checks++; if (cause !== 32'h0) begin errors++; $display("[TB] FAIL areset_cause got %h want %h", cause, 32'h0); end
    checks++; if (epc !== 32'h0) begin errors++; $display("[TB] FAIL areset_epc got %h want %h", epc, 32'h0); end
    checks++; if (interrupt_pending !== 1'b0) begin errors++; $display("[TB] FAIL areset_pending got %b want 0", interrupt_pending); end
    mfc0(5'd9, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL areset_count got %h want %h", d, 32'h0); end
    mfc0(5'd11, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL areset_compare got %h want %h", d, 32'h0); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mtc0(5'd11, 32'hFFFF_FFF0);
    repeat (5) step_cycle();
    mfc0(5'd9, d);
    checks++; if (d !== m_count) begin errors++; $display("[TB] FAIL post_reset_count got %h want %h", d, m_count); end
  endtask

  initial begin
    test_reset();
    test_write_masks();
    test_exception();
    test_priority();
    test_timer();
    test_hw_interrupt();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
